// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Instruction sequencer in front of the ALU. Fetches 16-bit words from
//   instruction memory, decodes them into the ALU operand/control fields,
//   waits EXEC_CYCLES for the ALU to settle, then writes the ALU result back
//   into an 8x16 register file. Owns the PC. Condition evaluation and flags
//   live in the ALU; this block only consumes alu_cond_ok.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   run                   level; start/continue execution from IDLE
//   imem_req/addr/ack/data  fetch handshake, request held until ack
//   alu_cond/op/reg1/reg2/ld_sh  registered ALU operand/control fields
//   alu_result, alu_cond_ok  ALU dest value and condition-check result
//   busy, halted          status
//   dbg_sel, dbg_data     combinational register-file debug read
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int PC_W        = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [1:0]      alu_cond,
    output logic [3:0]      alu_op,
    output logic [15:0]     alu_reg1,
    output logic [15:0]     alu_reg2,
    output logic [6:0]      alu_ld_sh,
    input  logic [15:0]     alu_result,
    input  logic            alu_cond_ok,
    output logic            busy,
    output logic            halted,
    input  logic [2:0]      dbg_sel,
    output logic [15:0]     dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      exec_cnt;
    logic [15:0]     rf [0:7];

    logic [3:0] ir_op;
    logic [2:0] ir_rd;
    logic [2:0] ir_rs1;
    logic [2:0] ir_rs2;
    logic       wb_write;

    assign ir_op  = ir[13:10];
    assign ir_rd  = ir[9:7];
    assign ir_rs1 = ir[6:4];
    assign ir_rs2 = ir[3:1];

    // Only ops 0000..1010 produce a register result; CMP (1011) and the
    // NOP/HALT range never write back.
    assign wb_write = alu_cond_ok && (ir_op <= 4'b1010);

    // Immediate / shift-amount extraction.
    function automatic logic [6:0] imm_field(input logic [15:0] instr);
        logic [3:0] op;
        op = instr[13:10];
        if (op == 4'b0110)
            return instr[6:0];
        else if (op >= 4'b1000 && op <= 4'b1010)
            return {3'b000, instr[3:0]};
        else
            return 7'd0;
    endfunction

    // Immediate-form ops reuse the Rs2 bit positions, so Rs2 is not read.
    function automatic logic uses_rs2(input logic [15:0] instr);
        logic [3:0] op;
        op = instr[13:10];
        return !(op >= 4'b1000 && op <= 4'b1010);
    endfunction

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ---- next state / status outputs ----
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (ir_op == 4'b1111)
                    state_nxt = S_HALT;
                else if (ir_op >= 4'b1100)
                    state_nxt = S_WB;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (exec_cnt == EXEC_LAST)
                    state_nxt = S_WB;
            end
            S_WB: begin
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc;

    // ---- fetch / decode / exec / writeback datapath ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            ir        <= '0;
            exec_cnt  <= '0;
            alu_cond  <= '0;
            alu_op    <= '0;
            alu_reg1  <= '0;
            alu_reg2  <= '0;
            alu_ld_sh <= '0;
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack)
                        ir <= imem_data;
                end
                S_DECODE: begin
                    alu_cond  <= ir[15:14];
                    alu_op    <= ir_op;
                    alu_reg1  <= rf[ir_rs1];
                    alu_reg2  <= uses_rs2(ir) ? rf[ir_rs2] : 16'd0;
                    alu_ld_sh <= imm_field(ir);
                    exec_cnt  <= '0;
                end
                S_EXEC: begin
                    exec_cnt <= exec_cnt + 4'd1;
                end
                S_WB: begin
                    if (wb_write)
                        rf[ir_rd] <= alu_result;
                    pc <= pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Combinational read: a write landing this cycle is seen next cycle.
    assign dbg_data = rf[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- DUT A: PC_W=8, EXEC_CYCLES=1 ----
    logic        rst_n, run, imem_req, imem_ack, alu_cond_ok, busy, halted;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data, alu_reg1, alu_reg2, alu_result, dbg_data;
    logic [1:0]  alu_cond;
    logic [3:0]  alu_op;
    logic [6:0]  alu_ld_sh;
    logic [2:0]  dbg_sel;

    alu_issue_ctrl #(.PC_W(8), .EXEC_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_cond(alu_cond), .alu_op(alu_op), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
        .alu_ld_sh(alu_ld_sh), .alu_result(alu_result), .alu_cond_ok(alu_cond_ok),
        .busy(busy), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // ---- DUT B: PC_W=2, EXEC_CYCLES=3 ----
    logic        rst_n_b, run_b, imem_req_b, imem_ack_b, alu_cond_ok_b, busy_b, halted_b;
    logic [1:0]  imem_addr_b;
    logic [15:0] imem_data_b, alu_reg1_b, alu_reg2_b, alu_result_b, dbg_data_b;
    logic [1:0]  alu_cond_b;
    logic [3:0]  alu_op_b;
    logic [6:0]  alu_ld_sh_b;
    logic [2:0]  dbg_sel_b;

    alu_issue_ctrl #(.PC_W(2), .EXEC_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .run(run_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b), .imem_data(imem_data_b),
        .alu_cond(alu_cond_b), .alu_op(alu_op_b), .alu_reg1(alu_reg1_b), .alu_reg2(alu_reg2_b),
        .alu_ld_sh(alu_ld_sh_b), .alu_result(alu_result_b), .alu_cond_ok(alu_cond_ok_b),
        .busy(busy_b), .halted(halted_b), .dbg_sel(dbg_sel_b), .dbg_data(dbg_data_b)
    );

    // Wait (bounded) for a fetch on DUT A, hold it for 'waits' cycles, ack one cycle.
    // Returns at the negedge after the ack cycle (DUT in DECODE).
    task automatic serve_fetch(input logic [15:0] word, input int waits, output bit ok);
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (imem_req === 1'b1);
        repeat (waits) @(negedge clk);
        imem_data = word;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'h0;
    endtask

    // Full instruction on DUT A; returns at the negedge after WB.
    task automatic run_instr(input logic [15:0] word, input logic [15:0] res,
                             input logic cok, output bit ok);
        alu_result  = res;
        alu_cond_ok = cok;
        serve_fetch(word, 0, ok);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst_n_b = 1'b0;
        run = 1'b0; run_b = 1'b0;
        imem_ack = 1'b0; imem_ack_b = 1'b0;
        imem_data = 16'h0; imem_data_b = 16'h0;
        alu_result = 16'h0; alu_result_b = 16'h0;
        alu_cond_ok = 1'b0; alu_cond_ok_b = 1'b0;
        dbg_sel = 3'd0; dbg_sel_b = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, busy, halted} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: req/busy/halted=%b required 000", {imem_req, busy, halted});
        end
        checks++;
        if ({alu_cond, alu_op, alu_reg1, alu_reg2, alu_ld_sh, imem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_alu_outs: op=%h r1=%h r2=%h ldsh=%h addr=%h required all 0",
                     alu_op, alu_reg1, alu_reg2, alu_ld_sh, imem_addr);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            checks++;
            if (dbg_data !== 16'h0) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h required 0000", i, dbg_data);
            end
        end
    endtask

    task automatic test_movn;
        int n = 0;
        run = 1'b1;
        alu_result  = 16'h0005;
        alu_cond_ok = 1'b1;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL movn_fetch: req=%b addr=%h busy=%b required 1 00 1", imem_req, imem_addr, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL movn_req_held: req=%b required 1", imem_req);
        end
        imem_data = 16'h2405;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_ld_sh !== 7'd5 || alu_cond !== 2'b00) begin
            errors++;
            $display("FAIL movn_ldsh: ld_sh=%0d cond=%b required 5 00", alu_ld_sh, alu_cond);
        end
        repeat (2) @(negedge clk);
        dbg_sel = 3'd0;
        #1;
        checks++;
        if (dbg_data !== 16'h0005 || imem_addr !== 8'd1) begin
            errors++;
            $display("FAIL movn_wb: R0=%h pc=%h required 0005 01", dbg_data, imem_addr);
        end
    endtask

    task automatic test_add;
        bit ok;
        run_instr(16'h1883, 16'h0003, 1'b1, ok);   // MOVn R1,3
        checks++;
        if (!ok) begin errors++; $display("FAIL add_ld1_timeout: no fetch request"); end
        run_instr(16'h1904, 16'h0004, 1'b1, ok);   // MOVn R2,4
        checks++;
        if (!ok) begin errors++; $display("FAIL add_ld2_timeout: no fetch request"); end
        dbg_sel = 3'd1; #1;
        checks++;
        if (dbg_data !== 16'h0003) begin
            errors++;
            $display("FAIL add_ld1: R1=%h required 0003", dbg_data);
        end

        // ADD R1,R1,R2 with condition passing
        alu_result  = 16'h0007;
        alu_cond_ok = 1'b1;
        serve_fetch(16'h0094, 0, ok);
        @(negedge clk);
        checks++;
        if (!ok || alu_reg1 !== 16'h0003 || alu_reg2 !== 16'h0004 || alu_op !== 4'b0000) begin
            errors++;
            $display("FAIL add_operands: ok=%b r1=%h r2=%h op=%b required 1 0003 0004 0000",
                     ok, alu_reg1, alu_reg2, alu_op);
        end
        @(negedge clk);                               // WB cycle
        dbg_sel = 3'd1; #1;
        checks++;
        if (dbg_data !== 16'h0003) begin
            errors++;
            $display("FAIL add_wb_read_old: R1=%h required 0003", dbg_data);
        end
        @(negedge clk); #1;
        checks++;
        if (dbg_data !== 16'h0007 || imem_req !== 1'b1 || imem_addr !== 8'd4) begin
            errors++;
            $display("FAIL add_wb: R1=%h req=%b pc=%h required 0007 1 04", dbg_data, imem_req, imem_addr);
        end

        // ADD again with condition failing; drop run mid-instruction
        alu_result  = 16'h0009;
        alu_cond_ok = 1'b0;
        serve_fetch(16'h0094, 1, ok);
        run = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (!ok || dbg_data !== 16'h0007 || imem_addr !== 8'd5) begin
            errors++;
            $display("FAIL add_cond_fail: ok=%b R1=%h pc=%h required 1 0007 05", ok, dbg_data, imem_addr);
        end
        checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL add_run_drop_idle: busy=%b req=%b required 0 0", busy, imem_req);
        end
        run = 1'b1;
    endtask

    task automatic test_cmp_halt;
        bit ok;
        alu_result  = 16'hFFFF;
        alu_cond_ok = 1'b1;
        serve_fetch(16'h6C94, 0, ok);                // CMP, Cond=01
        @(negedge clk);
        checks++;
        if (!ok || alu_op !== 4'b1011 || alu_cond !== 2'b01) begin
            errors++;
            $display("FAIL cmp_decode: ok=%b op=%b cond=%b required 1 1011 01", ok, alu_op, alu_cond);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp_r;
            exp_r = (i == 0) ? 16'h0005 : (i == 1) ? 16'h0007 : 16'h0004;
            dbg_sel = 3'(i); #1;
            checks++;
            if (dbg_data !== exp_r) begin
                errors++;
                $display("FAIL cmp_no_write R%0d: got %h required %h", i, dbg_data, exp_r);
            end
        end
        serve_fetch(16'h3C00, 0, ok);                // HALT
        @(negedge clk);
        checks++;
        if (!ok || halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'd6) begin
            errors++;
            $display("FAIL halt_enter: ok=%b halted=%b busy=%b req=%b pc=%h required 1 1 0 0 06",
                     ok, halted, busy, imem_req, imem_addr);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'd6) begin
            errors++;
            $display("FAIL halt_sticky: halted=%b busy=%b req=%b pc=%h required 1 0 0 06",
                     halted, busy, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset;
        int n;
        int lat;
        logic [1:0] exp_addr;
        run_b         = 1'b1;
        alu_result_b  = 16'h0011;
        alu_cond_ok_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (imem_req_b !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            exp_addr = 2'(i);
            checks++;
            if (imem_req_b !== 1'b1 || imem_addr_b !== exp_addr) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: req=%b addr=%0d required 1 %0d", i, imem_req_b, imem_addr_b, exp_addr);
            end
            imem_data_b = 16'h1981;                  // MOVn R3,1
            imem_ack_b  = 1'b1;
            @(negedge clk);
            imem_ack_b  = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (imem_req_b !== 1'b1 && lat < 20);
            checks++;
            if (lat != 5) begin
                errors++;
                $display("FAIL wrap_latency[%0d]: cycles=%0d required 5", i, lat);
            end
        end
        dbg_sel_b = 3'd3; #1;
        checks++;
        if (dbg_data_b !== 16'h0011 || imem_addr_b !== 2'd1) begin
            errors++;
            $display("FAIL wrap_state: R3=%h pc=%0d required 0011 1", dbg_data_b, imem_addr_b);
        end
        #2;
        rst_n_b = 1'b0;
        #1;
        checks++;
        if (imem_req_b !== 1'b0 || imem_addr_b !== 2'd0 || busy_b !== 1'b0 || dbg_data_b !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b pc=%0d busy=%b R3=%h required 0 0 0 0000",
                     imem_req_b, imem_addr_b, busy_b, dbg_data_b);
        end
        run_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
    endtask

    initial begin
        test_reset;
        test_movn;
        test_add;
        test_cmp_halt;
        test_wrap_and_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
